// File: rtl/mc_insertion.sv
// mc_insertion: NUM_CH per-channel circular FIFOs feeding one registered
// output slot through a round-robin arbiter. A beat accepted on a clock edge
// reaches the output register on the following edge, and the slot reloads in
// the same cycle it is consumed, giving one beat per cycle when busy.
// Optional build macro MC_INSERTION_STATS_EN adds the accepted_count,
// issued_count and stall_cycles counter ports.
module mc_insertion #(
  parameter int NUM_CH           = 4,
  parameter int MAX_DEPENDENCIES = 256,
  parameter int QUEUE_DEPTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  s_axis_tvalid,
  output logic [NUM_CH-1:0]                  s_axis_tready,
  input  logic [64*NUM_CH-1:0]               s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES*NUM_CH-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES*NUM_CH-1:0] s_axis_tdata_write_dependencies,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [63:0]                        m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]        m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]        m_axis_tdata_write_dependencies,
  output logic [$clog2(NUM_CH)-1:0]          m_axis_tdest,
  output logic [7*NUM_CH-1:0]                queue_occupancy,
  output logic [31:0]                        transactions_in_queue
`ifdef MC_INSERTION_STATS_EN
  ,
  output logic [31:0]                        accepted_count,
  output logic [31:0]                        issued_count,
  output logic [31:0]                        stall_cycles
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = PW + 1;
  localparam int MD   = MAX_DEPENDENCIES;

  logic [PW-1:0]   head [NUM_CH];
  logic [PW-1:0]   tail [NUM_CH];
  logic [CW-1:0]   count [NUM_CH];
  logic [63:0]     mem_id [NUM_CH][QUEUE_DEPTH];
  logic [MD-1:0]   mem_rd [NUM_CH][QUEUE_DEPTH];
  logic [MD-1:0]   mem_wr [NUM_CH][QUEUE_DEPTH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] nonempty;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic              grant_found;
  logic              load;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full queue.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      s_axis_tready[c] = (count[c] != CW'(QUEUE_DEPTH));
      push[c]          = s_axis_tvalid[c] && s_axis_tready[c];
      nonempty[c]      = (count[c] != CW'(0));
    end
  end

  // Round-robin pick: first non-empty channel after last_grant, wrapping.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_found && nonempty[(int'(last_grant) + i) % NUM_CH]) begin
        grant       = CH_W'((int'(last_grant) + i) % NUM_CH);
        grant_found = 1'b1;
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // The output slot reloads when empty or being consumed; the granted queue pops.
  always_comb begin
    load = grant_found && (!m_axis_tvalid || m_axis_tready);
    pop  = '0;
    if (load) begin
      pop[grant] = 1'b1;
    end else begin
      pop = '0;
    end
  end

  // Per-channel pointer and count bookkeeping; reset discards all stored beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c]  <= '0;
        tail[c]  <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) tail[c] <= tail[c] + PW'(1);
        if (pop[c])  head[c] <= head[c] + PW'(1);
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + CW'(1);
          2'b01:   count[c] <= count[c] - CW'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Payload storage; contents need no reset because the counts gate all reads.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_id[c][tail[c]] <= s_axis_tdata_owner_programID[64*c +: 64];
        mem_rd[c][tail[c]] <= s_axis_tdata_read_dependencies[MD*c +: MD];
        mem_wr[c][tail[c]] <= s_axis_tdata_write_dependencies[MD*c +: MD];
      end
    end
  end

  // Output register slot plus arbiter history; held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid                   <= 1'b0;
      m_axis_tdest                    <= '0;
      m_axis_tdata_owner_programID    <= 64'd0;
      m_axis_tdata_read_dependencies  <= '0;
      m_axis_tdata_write_dependencies <= '0;
      last_grant                      <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      m_axis_tvalid                   <= 1'b1;
      m_axis_tdest                    <= grant;
      m_axis_tdata_owner_programID    <= mem_id[grant][head[grant]];
      m_axis_tdata_read_dependencies  <= mem_rd[grant][head[grant]];
      m_axis_tdata_write_dependencies <= mem_wr[grant][head[grant]];
      last_grant                      <= grant;
    end else if (m_axis_tready) begin
      m_axis_tvalid                   <= 1'b0;
    end else begin
      m_axis_tvalid                   <= m_axis_tvalid;
    end
  end

  // Occupancy reporting straight from the registered counts and output valid.
  always_comb begin
    transactions_in_queue = {31'd0, m_axis_tvalid};
    for (int c = 0; c < NUM_CH; c++) begin
      queue_occupancy[7*c +: 7] = 7'(count[c]);
      transactions_in_queue     = transactions_in_queue + 32'(count[c]);
    end
  end

`ifdef MC_INSERTION_STATS_EN
  function automatic logic [31:0] popcount(input logic [NUM_CH-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < NUM_CH; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Free-running statistics counters; all wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_count <= 32'd0;
      issued_count   <= 32'd0;
      stall_cycles   <= 32'd0;
    end else begin
      accepted_count <= accepted_count + popcount(push);
      issued_count   <= issued_count + {31'd0, (m_axis_tvalid && m_axis_tready)};
      stall_cycles   <= stall_cycles + {31'd0, (m_axis_tvalid && !m_axis_tready)};
    end
  end
`endif

endmodule

// File: tb/tb_mc_insertion.sv
// Scoreboard bench for mc_insertion (NUM_CH=4, QUEUE_DEPTH=4). Stimulus pushes
// hand-ordered expected beats into a queue; a negedge monitor pops and compares
// every consumed output beat.
module tb_mc_insertion;
  localparam int NCH = 4;
  localparam int QD  = 4;
  localparam int MD  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    s_valid;
  logic [NCH-1:0]    s_ready;
  logic [64*NCH-1:0] s_id;
  logic [MD*NCH-1:0] s_rd;
  logic [MD*NCH-1:0] s_wr;
  logic              m_valid;
  logic              m_ready;
  logic [63:0]       m_id;
  logic [MD-1:0]     m_rd;
  logic [MD-1:0]     m_wr;
  logic [1:0]        m_dest;
  logic [7*NCH-1:0]  occ;
  logic [31:0]       total;
`ifdef MC_INSERTION_STATS_EN
  logic [31:0]       acc_cnt;
  logic [31:0]       iss_cnt;
  logic [31:0]       stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] id;
    logic [1:0]  dest;
  } exp_t;
  exp_t sb[$];

  mc_insertion #(.NUM_CH(NCH), .MAX_DEPENDENCIES(MD), .QUEUE_DEPTH(QD)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_valid),
    .s_axis_tready                   (s_ready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .m_axis_tvalid                   (m_valid),
    .m_axis_tready                   (m_ready),
    .m_axis_tdata_owner_programID    (m_id),
    .m_axis_tdata_read_dependencies  (m_rd),
    .m_axis_tdata_write_dependencies (m_wr),
    .m_axis_tdest                    (m_dest),
    .queue_occupancy                 (occ),
    .transactions_in_queue           (total)
`ifdef MC_INSERTION_STATS_EN
    ,
    .accepted_count                  (acc_cnt),
    .issued_count                    (iss_cnt),
    .stall_cycles                    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [MD-1:0] rd_of(input logic [63:0] id);
    return id[31:0] ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [MD-1:0] wr_of(input logic [63:0] id);
    return id[31:0] + 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_ch(input int ch, input logic [63:0] id);
    s_id[64*ch +: 64] = id;
    s_rd[MD*ch +: MD] = rd_of(id);
    s_wr[MD*ch +: MD] = wr_of(id);
    s_valid[ch]       = 1'b1;
  endtask

  // Offer one beat and hold it until accepted, bounded.
  task automatic push(input int ch, input logic [63:0] id);
    logic ok;
    int   n;
    set_ch(ch, id);
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready[ch];
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    s_valid[ch] = 1'b0;
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_beat(input logic [63:0] id, input logic [1:0] dest);
    exp_t e;
    e.id   = id;
    e.dest = dest;
    sb.push_back(e);
  endtask

  // Let everything drain with the consumer ready; bounded wait.
  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((m_valid || total != 32'd0 || sb.size() != 0) && n < 300);
    if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: every consumed beat must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", m_id, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_id",   m_id, e.id);
        chk("beat_rd",   64'(m_rd), 64'(rd_of(e.id)));
        chk("beat_wr",   64'(m_wr), 64'(wr_of(e.id)));
        chk("beat_dest", 64'(m_dest), 64'(e.dest));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic done33;

  initial begin
    rst_n   = 1'b0;
    s_valid = '0;
    s_id    = '0;
    s_rd    = '0;
    s_wr    = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_tready", 64'(s_ready), 64'hF);
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    chk("rst_occ",    64'(occ), 64'd0);
    chk("rst_total",  64'(total), 64'd0);
    chk("rst_tdest",  64'(m_dest), 64'd0);
    @(posedge clk); #1;

    // Single beat on ch2: accepted at edge 1, visible after edge 2, gone after edge 3
    expect_beat(64'h2A, 2'd2);
    set_ch(2, 64'h2A);
    @(posedge clk); #1;
    s_valid = '0;
    chk("single_not_yet", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    chk("single_valid", 64'(m_valid), 64'd1);
    chk("single_dest",  64'(m_dest), 64'd2);
    chk("single_id",    m_id, 64'h2A);
    @(posedge clk); #1;
    chk("single_clear", 64'(m_valid), 64'd0);
    drain();

    // All channels loaded with 3 beats, then released: strict 0,1,2,3 rotation
    m_ready = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      for (int b = 0; b < 3; b++)
        push(ch, 64'h200 + 64'(ch * 16 + b));
    for (int b = 0; b < 3; b++)
      for (int ch = 0; ch < NCH; ch++)
        expect_beat(64'h200 + 64'(ch * 16 + b), 2'(ch));
    chk("rr_total", 64'(total), 64'd12);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rr_no_bubble", 64'(m_valid), 64'd1);
    end
    @(negedge clk);
    chk("rr_end_idle", 64'(m_valid), 64'd0);
    drain();

    // Backpressure on ch1: queue takes 4 plus 1 in the output slot, 6th refused
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ch(1, 64'h101 + 64'(k));
      @(negedge clk);
      chk("bp_tready", 64'(s_ready[1]), (k < 5) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    s_valid = '0;
    for (int k = 0; k < 5; k++) expect_beat(64'h101 + 64'(k), 2'd1);
    chk("bp_full_ready", 64'(s_ready[1]), 64'd0);
    chk("bp_occ1",       64'(occ[13:7]), 64'd4);
    chk("bp_total",      64'(total), 64'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(m_valid), 64'd1);
      chk("bp_hold_id",    m_id, 64'h101);
      chk("bp_hold_rd",    64'(m_rd), 64'(rd_of(64'h101)));
      chk("bp_hold_dest",  64'(m_dest), 64'd1);
    end
    drain();
    chk("bp_ready_back", 64'(s_ready[1]), 64'd1);

    // Nine beats through ch0 with a toggling consumer: pointers wrap twice
    done33  = 1'b0;
    m_ready = 1'b0;
    for (int k = 1; k <= 9; k++) expect_beat(64'(k), 2'd0);
    fork
      begin
        for (int k = 1; k <= 9; k++) push(0, 64'(k));
        done33 = 1'b1;
      end
      begin
        while (!done33) begin
          @(posedge clk); #1;
          m_ready = ~m_ready;
        end
      end
    join
    drain();
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with 3 beats queued on ch3: immediate flush, nothing stale afterwards
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(3, 64'h400 + 64'(k));
    chk("pre_rst_total", 64'(total), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_occ",   64'(occ), 64'd0);
    chk("rst_mid_total", 64'(total), 64'd0);
    chk("rst_mid_id",    m_id, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 64'(s_ready), 64'hF);
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(m_valid), 64'd0);
    end
    @(posedge clk); #1;

`ifdef MC_INSERTION_STATS_EN
    // Five beats, output stalled for exactly three valid cycles
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) expect_beat(64'h51 + 64'(k), 2'd0);
    for (int k = 0; k < 5; k++) push(0, 64'h51 + 64'(k));
    m_ready = 1'b1;
    drain();
    chk("stat_accepted", 64'(acc_cnt), 64'd5);
    chk("stat_issued",   64'(iss_cnt), 64'd5);
    chk("stat_stall",    64'(stall_cnt), 64'd3);
`endif

    drain();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
